// File: rtl/uart_host_bridge.sv
// Host-side bridge to a simple UART. It holds a TX and an RX byte FIFO, runs a transmit
// sequencer, and defers baud/char-size reconfiguration until the transmitter is idle.
module uart_host_bridge #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [11:0] UBRR_INIT  = 12'd650,
  parameter logic [3:0]  UCSZ_INIT  = 4'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] cfg_ubrr_i,
  input  logic [3:0]  cfg_ucsz_i,
  input  logic        cfg_wr_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic        rx_overflow_o,
  input  logic        clr_ovf_i,
  output logic [11:0] ubrr_o,
  output logic [3:0]  ucsz_o,
  output logic [1:0]  ucr_o,
  output logic [7:0]  udrt_o,
  input  logic [1:0]  usr_i,
  input  logic [7:0]  udrr_i
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL    = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic [1:0] {T_IDLE, T_LOAD, T_BUSY, T_CFG} txState_e;

  txState_e      state_q, state_d;
  logic [7:0]    txMem [FIFO_DEPTH];
  logic [7:0]    rxMem [FIFO_DEPTH];
  logic [AW-1:0] txWr_q, txWr_d, txRd_q, txRd_d, rxWr_q, rxWr_d, rxRd_q, rxRd_d;
  logic [CW-1:0] txCnt_q, txCnt_d, rxCnt_q, rxCnt_d;
  logic [1:0]    usrMeta_q, usrSync_q;
  logic          rxRdyPrev_q;
  logic          pending_q, pending_d;
  logic [11:0]   cfgUbrr_q, cfgUbrr_d, ubrr_q, ubrr_d;
  logic [3:0]    cfgUcsz_q, cfgUcsz_d, ucsz_q, ucsz_d;
  logic [7:0]    udrt_q, udrt_d;
  logic [1:0]    cfgCnt_q, cfgCnt_d;
  logic          ovf_q, ovf_d;
  logic          txPush, txPop, rxPush, rxPop, rxEdge, txFull, rxFull;

  // USR bit 1 is the UART's rx_ready, bit 0 its tx_idle; only the synchronized copy is used.
  assign txFull = (txCnt_q == FULL);
  assign rxFull = (rxCnt_q == FULL);
  assign txPush = tx_valid_i && !txFull;
  assign txPop  = (state_q == T_IDLE) && !pending_q && (txCnt_q != '0) && usrSync_q[0];
  assign rxEdge = usrSync_q[1] && !rxRdyPrev_q && (state_q != T_CFG);
  assign rxPop  = rx_valid_o && rx_ready_i;
  assign rxPush = rxEdge && (!rxFull || rxPop);

  assign tx_ready_o    = !txFull;
  assign rx_valid_o    = (rxCnt_q != '0);
  assign rx_data_o     = rx_valid_o ? rxMem[rxRd_q] : 8'h00;
  assign rx_overflow_o = ovf_q;
  assign ubrr_o        = ubrr_q;
  assign ucsz_o        = ucsz_q;
  assign udrt_o        = udrt_q;

  always_comb begin
    txWr_d  = txPush ? txWr_q + PTR_ONE : txWr_q;
    txRd_d  = txPop  ? txRd_q + PTR_ONE : txRd_q;
    rxWr_d  = rxPush ? rxWr_q + PTR_ONE : rxWr_q;
    rxRd_d  = rxPop  ? rxRd_q + PTR_ONE : rxRd_q;
    txCnt_d = txCnt_q;
    rxCnt_d = rxCnt_q;
    if (txPush && !txPop) txCnt_d = txCnt_q + CNT_ONE;
    else if (!txPush && txPop) txCnt_d = txCnt_q - CNT_ONE;
    if (rxPush && !rxPop) rxCnt_d = rxCnt_q + CNT_ONE;
    else if (!rxPush && rxPop) rxCnt_d = rxCnt_q - CNT_ONE;
    // A dropped byte outranks a same-cycle clear so the loss is never hidden.
    if (rxEdge && rxFull && !rxPop) ovf_d = 1'b1;
    else if (clr_ovf_i) ovf_d = 1'b0;
    else ovf_d = ovf_q;
  end

  always_comb begin
    state_d   = state_q;
    ubrr_d    = ubrr_q;
    ucsz_d    = ucsz_q;
    udrt_d    = udrt_q;
    cfgCnt_d  = cfgCnt_q;
    ucr_o     = 2'b10;
    pending_d = pending_q | cfg_wr_i;
    cfgUbrr_d = cfg_wr_i ? cfg_ubrr_i : cfgUbrr_q;
    cfgUcsz_d = cfg_wr_i ? cfg_ucsz_i : cfgUcsz_q;
    unique case (state_q)
      T_IDLE: begin
        if (pending_q) begin
          state_d   = T_CFG;
          ubrr_d    = cfgUbrr_q;
          ucsz_d    = cfgUcsz_q;
          cfgCnt_d  = 2'd0;
          pending_d = cfg_wr_i;
        end else if (txPop) begin
          state_d = T_LOAD;
          udrt_d  = txMem[txRd_q];
        end
      end
      T_LOAD: begin
        ucr_o = 2'b11;
        if (!usrSync_q[0]) state_d = T_BUSY;
      end
      T_BUSY: begin
        if (usrSync_q[0]) state_d = T_IDLE;
      end
      T_CFG: begin
        // Holding UCR at zero keeps the UART in reset while the new rate settles.
        ucr_o = 2'b00;
        if (cfgCnt_q == 2'd3) state_d = T_IDLE;
        else cfgCnt_d = cfgCnt_q + 2'd1;
      end
      default: state_d = T_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (txPush) txMem[txWr_q] <= tx_data_i;
    if (rxPush) rxMem[rxWr_q] <= udrr_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= T_IDLE;
      txWr_q      <= '0;
      txRd_q      <= '0;
      rxWr_q      <= '0;
      rxRd_q      <= '0;
      txCnt_q     <= '0;
      rxCnt_q     <= '0;
      usrMeta_q   <= 2'b00;
      usrSync_q   <= 2'b00;
      rxRdyPrev_q <= 1'b0;
      pending_q   <= 1'b0;
      cfgUbrr_q   <= UBRR_INIT;
      cfgUcsz_q   <= UCSZ_INIT;
      ubrr_q      <= UBRR_INIT;
      ucsz_q      <= UCSZ_INIT;
      udrt_q      <= 8'h00;
      cfgCnt_q    <= 2'd0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      txWr_q      <= txWr_d;
      txRd_q      <= txRd_d;
      rxWr_q      <= rxWr_d;
      rxRd_q      <= rxRd_d;
      txCnt_q     <= txCnt_d;
      rxCnt_q     <= rxCnt_d;
      usrMeta_q   <= usr_i;
      usrSync_q   <= usrMeta_q;
      rxRdyPrev_q <= usrSync_q[1];
      pending_q   <= pending_d;
      cfgUbrr_q   <= cfgUbrr_d;
      cfgUcsz_q   <= cfgUcsz_d;
      ubrr_q      <= ubrr_d;
      ucsz_q      <= ucsz_d;
      udrt_q      <= udrt_d;
      cfgCnt_q    <= cfgCnt_d;
      ovf_q       <= ovf_d;
    end
  end
endmodule

// File: tb/tb_uart_host_bridge.sv
// Self-checking bench for uart_host_bridge: vector tables for the FIFO fill cases,
// byte scoreboards for TX/RX ordering, and hand-written config and reset sequences.
module tb_uart_host_bridge;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstN;
  logic [11:0] cfgUbrr;
  logic [3:0]  cfgUcsz;
  logic        cfgWr;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;
  logic [7:0]  rxData;
  logic        rxValid;
  logic        rxReady;
  logic        rxOverflow;
  logic        clrOvf;
  logic [11:0] ubrr;
  logic [3:0]  ucsz;
  logic [1:0]  ucr;
  logic [7:0]  udrt;
  logic [1:0]  usr;
  logic [7:0]  udrr;

  always #5 clk = ~clk;

  uart_host_bridge #(.FIFO_DEPTH(DEPTH), .UBRR_INIT(12'd650), .UCSZ_INIT(4'd8)) dut (
    .clk(clk), .rst_n(rstN),
    .cfg_ubrr_i(cfgUbrr), .cfg_ucsz_i(cfgUcsz), .cfg_wr_i(cfgWr),
    .tx_data_i(txData), .tx_valid_i(txValid), .tx_ready_o(txReady),
    .rx_data_o(rxData), .rx_valid_o(rxValid), .rx_ready_i(rxReady),
    .rx_overflow_o(rxOverflow), .clr_ovf_i(clrOvf),
    .ubrr_o(ubrr), .ucsz_o(ucsz), .ucr_o(ucr), .udrt_o(udrt),
    .usr_i(usr), .udrr_i(udrr)
  );

  typedef struct { logic [7:0] data; logic expReady; } txVec_t;
  typedef struct { logic [7:0] udrr; logic expOvf; logic [7:0] expHead; } rxVec_t;

  txVec_t     txTable [9];
  rxVec_t     rxTable [9];
  logic [7:0] txQueue [$];
  logic [7:0] rxQueue [$];
  int         checks = 0;
  int         errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Host pushes one TX byte; the model accepts it only while its FIFO image has room.
  task automatic applyStimulus(input logic [7:0] b);
    txData  = b;
    txValid = 1'b1;
    if (txQueue.size() < DEPTH) txQueue.push_back(b);
    @(negedge clk);
    txValid = 1'b0;
  endtask

  // One UART rx_ready pulse long enough to clear the synchronizer and edge detector.
  task automatic rxPulse(input logic [7:0] b);
    udrr   = b;
    usr[1] = 1'b1;
    if (rxQueue.size() < DEPTH) rxQueue.push_back(b);
    repeat (4) @(negedge clk);
    usr[1] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic waitTe(input logic level, input int maxCycles, input string name);
    int n = 0;
    while (ucr[0] !== level && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(ucr[0]), 32'(level));
  endtask

  // Acts as the UART for one byte: sees te, checks the byte order, goes busy, then idle.
  task automatic txServe(input string name);
    waitTe(1'b1, 12, {name, "_te_rise"});
    if (txQueue.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_queue: got load, expected none", name);
    end else begin
      checkOutput({name, "_udrt"}, 32'(udrt), 32'(txQueue.pop_front()));
    end
    usr[0] = 1'b0;
    waitTe(1'b0, 8, {name, "_te_fall"});
    checkOutput({name, "_ucr_busy"}, 32'(ucr), 32'(2'b10));
    usr[0] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    for (int i = 0; i < 9; i++) begin
      txTable[i] = '{data: 8'h10 + 8'(i), expReady: (i < DEPTH - 1)};
      rxTable[i] = '{udrr: 8'(i + 1), expOvf: (i >= DEPTH), expHead: 8'h01};
    end

    rstN = 1'b0; cfgUbrr = '0; cfgUcsz = '0; cfgWr = 1'b0; txData = '0; txValid = 1'b0;
    rxReady = 1'b0; clrOvf = 1'b0; usr = 2'b01; udrr = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ubrr", 32'(ubrr), 32'(12'd650));
    checkOutput("rst_ucsz", 32'(ucsz), 32'(4'd8));
    checkOutput("rst_ucr", 32'(ucr), 32'(2'b10));
    checkOutput("rst_udrt", 32'(udrt), 32'(8'h00));
    checkOutput("rst_tx_ready", 32'(txReady), 32'(1));
    checkOutput("rst_rx_valid", 32'(rxValid), 32'(0));
    checkOutput("rst_rx_data", 32'(rxData), 32'(8'h00));
    checkOutput("rst_ovf", 32'(rxOverflow), 32'(0));
    rstN = 1'b1;
    repeat (4) @(negedge clk);

    // Single byte with the UART idle: te must rise within two cycles of tx_valid.
    applyStimulus(8'hA5);
    waitTe(1'b1, 1, "lat_te");
    txServe("single");
    repeat (3) @(negedge clk);

    // Fill the TX FIFO while the UART is busy, then drain in order.
    usr[0] = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(txTable[i].data);
      checkOutput($sformatf("fill_ready_%0d", i), 32'(txReady), 32'(txTable[i].expReady));
    end
    usr[0] = 1'b1;
    for (int i = 0; i < DEPTH; i++) txServe($sformatf("drain_%0d", i));
    repeat (4) @(negedge clk);
    checkOutput("drain_ucr", 32'(ucr), 32'(2'b10));
    checkOutput("drain_tx_ready", 32'(txReady), 32'(1));

    // Reconfigure during T_BUSY: deferred until the byte completes, last write wins.
    applyStimulus(8'h5A);
    waitTe(1'b1, 4, "cfg_te");
    checkOutput("cfg_udrt", 32'(udrt), 32'(txQueue.pop_front()));
    usr[0] = 1'b0;
    waitTe(1'b0, 6, "cfg_busy");
    cfgUbrr = 12'd100; cfgUcsz = 4'd5; cfgWr = 1'b1;
    @(negedge clk);
    cfgUbrr = 12'd54; cfgUcsz = 4'd7;
    @(negedge clk);
    cfgWr = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("cfg_hold_ubrr", 32'(ubrr), 32'(12'd650));
    checkOutput("cfg_hold_ucr", 32'(ucr), 32'(2'b10));
    usr[0] = 1'b1;
    cnt = 0;
    while (ucr !== 2'b00 && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("cfg_enter_ucr", 32'(ucr), 32'(2'b00));
    checkOutput("cfg_ubrr", 32'(ubrr), 32'(12'd54));
    checkOutput("cfg_ucsz", 32'(ucsz), 32'(4'd7));
    cnt = 0;
    while (ucr === 2'b00 && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("cfg_window", 32'(cnt), 32'(4));
    checkOutput("cfg_exit_ucr", 32'(ucr), 32'(2'b10));

    // RX overflow: nine captures into an eight-entry FIFO with nobody popping.
    for (int i = 0; i < 9; i++) begin
      rxPulse(rxTable[i].udrr);
      checkOutput($sformatf("rx_ovf_%0d", i), 32'(rxOverflow), 32'(rxTable[i].expOvf));
      checkOutput($sformatf("rx_head_%0d", i), 32'(rxData), 32'(rxTable[i].expHead));
    end
    clrOvf = 1'b1;
    @(negedge clk);
    clrOvf = 1'b0;
    checkOutput("ovf_clear", 32'(rxOverflow), 32'(0));

    // Full RX FIFO: capture and pop land on the same edge.
    udrr   = 8'hAA;
    usr[1] = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("fullpp_head", 32'(rxData), 32'(rxQueue[0]));
    rxReady = 1'b1;
    @(negedge clk);
    rxReady = 1'b0;
    void'(rxQueue.pop_front());
    rxQueue.push_back(8'hAA);
    checkOutput("fullpp_ovf", 32'(rxOverflow), 32'(0));
    checkOutput("fullpp_next", 32'(rxData), 32'(rxQueue[0]));
    usr[1] = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput($sformatf("rx_valid_%0d", i), 32'(rxValid), 32'(1));
      checkOutput($sformatf("rx_data_%0d", i), 32'(rxData), 32'(rxQueue.pop_front()));
      rxReady = 1'b1;
      @(negedge clk);
      rxReady = 1'b0;
    end
    checkOutput("rx_empty", 32'(rxValid), 32'(0));

    // Asynchronous reset while in T_LOAD with bytes still queued.
    rxPulse(8'h5C);
    checkOutput("pre_rst_rx_valid", 32'(rxValid), 32'(1));
    for (int i = 0; i < 4; i++) applyStimulus(8'hF0 + 8'(i));
    waitTe(1'b1, 4, "pre_rst_load");
    #2 rstN = 1'b0;
    #1;
    checkOutput("arst_ucr", 32'(ucr), 32'(2'b10));
    checkOutput("arst_tx_ready", 32'(txReady), 32'(1));
    checkOutput("arst_rx_valid", 32'(rxValid), 32'(0));
    checkOutput("arst_udrt", 32'(udrt), 32'(8'h00));
    txQueue.delete();
    rxQueue.delete();
    @(negedge clk);
    rstN = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("post_rst_no_load", 32'(ucr), 32'(2'b10));
    applyStimulus(8'h3C);
    txServe("resume");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_host_bridge.md
UART_HOST_BRIDGE -- requirements
Module: uart_host_bridge

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, entries per TX and per RX FIFO (power of 2, >=2).
REQ-002 Parameter UBRR_INIT, default 12'd650, UBRR value driven after reset.
REQ-003 Parameter UCSZ_INIT, default 4'd8, UCSZ value driven after reset.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 cfg_ubrr / cfg_ucsz / cfg_wr  input  12 / 4 / 1  new baud divisor / char size, and a 1-cycle load strobe.
REQ-007 tx_data / tx_valid / tx_ready  in / in / out  8 / 1 / 1  host byte stream into TX FIFO; tx_ready = TX FIFO not full.
REQ-008 rx_data / rx_valid / rx_ready  out / out / in  8 / 1 / 1  received byte stream out of RX FIFO; rx_valid = RX FIFO not empty.
REQ-009 rx_overflow  output  1  sticky flag: a received byte was dropped; clr_ovf  input  1  clears it.
REQ-010 UBRR / UCSZ / UCR / UDRT  output  12 / 4 / 2 / 8  register drive into the UART peripheral (UCR[0]=te, UCR[1]=rx_en).
REQ-011 USR / UDRR  input  2 / 8  UART status {rx_ready, tx_idle} and received data.

Function
REQ-012 Push into TX FIFO when tx_valid && tx_ready; pop from RX FIFO when rx_valid && rx_ready; rx_data = RX FIFO head, combinational, stable until popped.
REQ-013 Both FIFOs circular with wrapping pointers and an occupancy count 0..FIFO_DEPTH; simultaneous push and pop in the same cycle leaves the count unchanged, including when full, in which case the push is accepted.
REQ-014 USR passes through a 2-flop synchronizer before use; all decisions use the synchronized value.
REQ-015 TX FSM states: T_IDLE, T_LOAD, T_BUSY, T_CFG.
REQ-016 T_IDLE -> T_CFG when a configuration is pending (takes priority).
REQ-017 T_IDLE -> T_LOAD when the TX FIFO is non-empty and sync tx_idle=1; the FIFO head is popped into the UDRT register in the same cycle.
REQ-018 T_LOAD holds te=1 and UDRT stable until sync tx_idle=0, then -> T_BUSY with te=0.
REQ-019 T_BUSY -> T_IDLE when sync tx_idle=1; UDRT holds its last value.
REQ-020 T_CFG drives UBRR<=cfg latch, UCSZ<=cfg latch, UCR=2'b00 for 4 clk cycles (UART reset window), then -> T_IDLE with rx_en restored to 1.
REQ-021 cfg_wr latches cfg_ubrr/cfg_ucsz in any state and sets pending; it is applied only from T_IDLE, so an in-flight byte is never cut off.
REQ-022 A second cfg_wr before the config is applied overwrites the latch, last write wins; cfg_wr during T_CFG re-arms pending.
REQ-023 Capture one UDRR byte into the RX FIFO on each rising edge of sync rx_ready.
REQ-024 If the RX FIFO is full at capture with no pop that cycle, drop the byte and set rx_overflow; the FIFO contents are unchanged.
REQ-025 rx_overflow clears on clr_ovf; a set and a clear in the same cycle leave it set.
REQ-026 rx_ready edges during T_CFG are ignored.
REQ-027 Worst-case latency from tx_valid (FIFO empty, UART idle) to te=1 is 2 clk cycles.

Reset
REQ-028 rst low, asynchronously: FIFOs empty, pointers 0, FSM T_IDLE, pending=0, synchronizer flops 0, rx_overflow=0.
REQ-029 Outputs during reset: UBRR=UBRR_INIT, UCSZ=UCSZ_INIT, UCR=2'b10, UDRT=8'h00, tx_ready=1, rx_valid=0, rx_data=8'h00.
REQ-030 Reset asserted mid-transfer aborts immediately; all queued bytes are discarded.
REQ-031 Operation resumes on the first clk edge after rst is deasserted.

Verification
REQ-032 Push 8'hA5 with USR=2'b01 -> UCR[0]=1 and UDRT=8'hA5 within 2 cycles; drive USR[0]=0 -> te drops; USR[0]=1 -> FSM back to T_IDLE.
REQ-033 Push 9 bytes with FIFO_DEPTH=8 while UART busy -> tx_ready=0 after the 8th; the 9th is not accepted; after drain, bytes appear on UDRT in push order.
REQ-034 9 rx_ready rising edges with UDRR=8'h01..8'h09 and rx_ready=0 -> FIFO holds 01..08, rx_overflow=1; clr_ovf -> rx_overflow=0.
REQ-035 cfg_wr with ubrr=12'd54 during T_BUSY -> UBRR unchanged until the byte completes, then UBRR=54 and UCR=00 for 4 cycles, then UCR=10.
REQ-036 Assert rst during T_LOAD with 3 bytes queued -> UCR=10, tx_ready=1, rx_valid=0 immediately, without a clk edge.
REQ-037 Push and pop simultaneously on a full RX FIFO with a capture edge -> count stays 8, no overflow, head advances.
